// File: rtl/decode_stage.sv
// decode_stage: pipelined RISC-V instruction decode.
// Decodes one instruction per cycle into a single output register with
// valid/ready back-pressure and flush. Holds the architectural register file,
// with optional write-back forwarding and operand refresh while stalled.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rd1,
  output logic [XLEN-1:0] out_rd2,
  output logic [1:0]      out_alu_op,
  output logic [3:0]      out_alu_control,
  output logic            out_illegal
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_LIM = 6'(NREGS);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_OP     = 7'h33;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // Register index beyond the configured register count (only possible for RV32E).
  function automatic logic idx_oob(input logic [4:0] idx);
    return {1'b0, idx} >= NREGS_LIM;
  endfunction

  // ALU function from func3; alt selects SUB (func3=000) or SRA (func3=101).
  function automatic logic [3:0] alu_func(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // Instruction fields
  logic [6:0] opcode_next;
  logic [4:0] rd_next;
  logic [2:0] func3_next;
  logic [4:0] rs1_next;
  logic [4:0] rs2_next;
  logic [6:0] func7_next;

  assign opcode_next = in_instr[6:0];
  assign rd_next     = in_instr[11:7];
  assign func3_next  = in_instr[14:12];
  assign rs1_next    = in_instr[19:15];
  assign rs2_next    = in_instr[24:20];
  assign func7_next  = in_instr[31:25];

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_next;
  logic [1:0]      alu_op_next;
  logic [3:0]      alu_ctrl_raw;
  logic [3:0]      alu_ctrl_next;
  logic            opc_illegal;
  logic            r_illegal;
  logic            reg_illegal;
  logic            illegal_next;
  logic            uses_rd;
  logic            uses_rs1;
  logic            uses_rs2;

  // Format decode: immediate, ALU class/function and which register fields are live.
  always_comb begin
    imm32        = '0;
    alu_op_next  = 2'b00;
    alu_ctrl_raw = ALU_ADD;
    opc_illegal  = 1'b0;
    r_illegal    = 1'b0;
    uses_rd      = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    case (opcode_next)
      OP_LOAD, OP_JALR: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_IMM: begin
        imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
        alu_op_next  = 2'b11;
        alu_ctrl_raw = alu_func(func3_next, func7_next[5] && (func3_next == 3'b101));
        uses_rd      = 1'b1;
        uses_rs1     = 1'b1;
      end
      OP_STORE: begin
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm32        = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
        alu_op_next  = 2'b01;
        alu_ctrl_raw = ALU_SUB;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OP_LUI: begin
        imm32        = {in_instr[31:12], 12'b0};
        alu_ctrl_raw = ALU_PASSB;
        uses_rd      = 1'b1;
      end
      OP_AUIPC: begin
        imm32   = {in_instr[31:12], 12'b0};
        uses_rd = 1'b1;
      end
      OP_JAL: begin
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
        uses_rd = 1'b1;
      end
      OP_OP: begin
        alu_op_next  = 2'b10;
        alu_ctrl_raw = alu_func(func3_next, func7_next[5]);
        r_illegal    = !((func7_next == 7'h00) ||
                         ((func7_next == 7'h20) &&
                          ((func3_next == 3'b000) || (func3_next == 3'b101))));
        uses_rd      = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      default: opc_illegal = 1'b1;
    endcase
  end

  assign reg_illegal   = (uses_rd && idx_oob(rd_next)) ||
                         (uses_rs1 && idx_oob(rs1_next)) ||
                         (uses_rs2 && idx_oob(rs2_next));
  assign illegal_next  = opc_illegal || r_illegal || reg_illegal;
  assign alu_ctrl_next = illegal_next ? ALU_ADD : alu_ctrl_raw;
  assign imm_next      = XLEN'($signed(imm32));

  // Handshake
  logic out_valid_reg;
  logic accept;
  logic wr_en;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign wr_en    = we && (wa != 5'd0) && !idx_oob(wa);

  // Register file; x0 is never written so it stays at zero.
  logic [XLEN-1:0] rf_reg [NREGS];

  // Write-back into the register file; cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_reg[i] <= '0;
    end else if (wr_en) begin
      rf_reg[wa[IDXW-1:0]] <= wd;
    end
  end

  // Output register fields
  logic [XLEN-1:0] pc_reg;
  logic [6:0]      opcode_reg;
  logic [4:0]      rd_reg;
  logic [2:0]      func3_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [6:0]      func7_reg;
  logic [XLEN-1:0] imm_reg;
  logic [1:0]      alu_op_reg;
  logic [3:0]      alu_ctrl_reg;
  logic            illegal_reg;

  // Operand read ports: index 0 is rs1, index 1 is rs2.
  logic [1:0][4:0]      rs_new;
  logic [1:0][4:0]      rs_held;
  logic [1:0][XLEN-1:0] opnd;

  assign rs_new  = {rs2_next, rs1_next};
  assign rs_held = {rs2_reg, rs1_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [XLEN-1:0] rf_val;
      logic [XLEN-1:0] opnd_next;
      logic [XLEN-1:0] opnd_reg;
      logic            bypass_hit;
      logic            refresh_hit;

      assign rf_val      = ((rs_new[gi] != 5'd0) && !idx_oob(rs_new[gi])) ?
                           rf_reg[rs_new[gi][IDXW-1:0]] : '0;
      assign bypass_hit  = (BYPASS != 0) && wr_en && (wa == rs_new[gi]);
      assign opnd_next   = bypass_hit ? wd : rf_val;
      // A stalled instruction must not execute with an operand that was
      // overwritten after it was decoded.
      assign refresh_hit = out_valid_reg && !out_ready && wr_en && (wa == rs_held[gi]);

      // Capture the operand on accept, refresh it from write-back while stalled.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          opnd_reg <= '0;
        end else if (accept) begin
          opnd_reg <= opnd_next;
        end else if (refresh_hit) begin
          opnd_reg <= wd;
        end
      end

      assign opnd[gi] = opnd_reg;
    end
  endgenerate

  // Output valid: flush wins, then accept, otherwise drain when consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Decoded fields load only on accept and otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= '0;
      opcode_reg   <= '0;
      rd_reg       <= '0;
      func3_reg    <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      func7_reg    <= '0;
      imm_reg      <= '0;
      alu_op_reg   <= '0;
      alu_ctrl_reg <= '0;
      illegal_reg  <= 1'b0;
    end else if (accept) begin
      pc_reg       <= in_pc;
      opcode_reg   <= opcode_next;
      rd_reg       <= rd_next;
      func3_reg    <= func3_next;
      rs1_reg      <= rs1_next;
      rs2_reg      <= rs2_next;
      func7_reg    <= func7_next;
      imm_reg      <= imm_next;
      alu_op_reg   <= alu_op_next;
      alu_ctrl_reg <= alu_ctrl_next;
      illegal_reg  <= illegal_next;
    end
  end

  assign out_valid       = out_valid_reg;
  assign out_pc          = pc_reg;
  assign out_opcode      = opcode_reg;
  assign out_rd          = rd_reg;
  assign out_func3       = func3_reg;
  assign out_rs1         = rs1_reg;
  assign out_rs2         = rs2_reg;
  assign out_func7       = func7_reg;
  assign out_imm         = imm_reg;
  assign out_rd1         = opnd[0];
  assign out_rd2         = opnd[1];
  assign out_alu_op      = alu_op_reg;
  assign out_alu_control = alu_ctrl_reg;
  assign out_illegal     = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode vectors plus hand-written handshake,
// flush and reset sequences. Expected results go into a scoreboard queue when
// an instruction is accepted and are compared while the DUT holds them.
// A second instance (RV32E, no bypass) shares the stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm, out_rd1, out_rd2;
  logic [6:0]  out_opcode, out_func7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_func3;
  logic [1:0]  out_alu_op;
  logic [3:0]  out_alu_control;

  logic        e_in_ready, e_out_valid, e_out_illegal;
  logic [31:0] e_out_pc, e_out_imm, e_out_rd1, e_out_rd2;
  logic [6:0]  e_out_opcode, e_out_func7;
  logic [4:0]  e_out_rd, e_out_rs1, e_out_rs2;
  logic [2:0]  e_out_func3;
  logic [1:0]  e_out_alu_op;
  logic [3:0]  e_out_alu_control;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .we(we), .wa(wa), .wd(wd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_func3(out_func3), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func7(out_func7), .out_imm(out_imm), .out_rd1(out_rd1),
    .out_rd2(out_rd2), .out_alu_op(out_alu_op),
    .out_alu_control(out_alu_control), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32), .NREGS(16), .BYPASS(0)) dut_e (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .we(we), .wa(wa), .wd(wd),
    .flush(flush), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_out_pc), .out_opcode(e_out_opcode), .out_rd(e_out_rd),
    .out_func3(e_out_func3), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2),
    .out_func7(e_out_func7), .out_imm(e_out_imm), .out_rd1(e_out_rd1),
    .out_rd2(e_out_rd2), .out_alu_op(e_out_alu_op),
    .out_alu_control(e_out_alu_control), .out_illegal(e_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] imm;
    logic [1:0]  op;
    bit          chk_op;
    logic [3:0]  ctrl;
    bit          ill;
    bit          ill_e;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  op;
    bit          chk_op;
    logic [3:0]  ctrl;
    bit          ill;
    bit          ill_e;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] m_rf [32];
  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        vecs[25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present an instruction and record its expected decode.
  task automatic drive(input logic [31:0] instr, input logic [31:0] imm, input logic [1:0] op,
                       input bit chk_op, input logic [3:0] ctrl, input bit ill, input bit ill_e);
    in_valid   = 1'b1;
    in_instr   = instr;
    cur.instr  = instr;
    cur.imm    = imm;
    cur.op     = op;
    cur.chk_op = chk_op;
    cur.ctrl   = ctrl;
    cur.ill    = ill;
    cur.ill_e  = ill_e;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    we = en;
    wa = a;
    wd = d;
  endtask

  // One clock: update the scoreboard from the inputs, clock, compare held output.
  task automatic step();
    exp_t        r;
    logic [31:0] ins;
    bit          mv, acc, wq;
    #1;
    mv = (exp_q.size() != 0);
    chk("in_ready", in_ready, !mv || out_ready);
    chk("e_in_ready", e_in_ready, !mv || out_ready);
    acc = in_valid && (!mv || out_ready) && !flush;
    wq  = we && (wa != 5'd0);
    if (flush) exp_q.delete();
    else if (mv && out_ready) void'(exp_q.pop_front());
    else if (mv && wq) begin
      ins = exp_q[0].instr;
      if (ins[19:15] == wa) exp_q[0].rd1 = wd;
      if (ins[24:20] == wa) exp_q[0].rd2 = wd;
    end
    if (acc) begin
      r     = cur;
      r.pc  = in_pc;
      ins   = in_instr;
      r.rd1 = (wq && wa == ins[19:15]) ? wd : m_rf[ins[19:15]];
      r.rd2 = (wq && wa == ins[24:20]) ? wd : m_rf[ins[24:20]];
      exp_q.push_back(r);
      $display("txn pc=%08h instr=%08h rd1=%0d rd2=%0d", r.pc, r.instr, r.rd1, r.rd2);
    end
    if (wq) m_rf[wa] = wd;
    @(posedge clk);
    #1;
    mv = (exp_q.size() != 0);
    chk("out_valid", out_valid, mv);
    chk("e_out_valid", e_out_valid, mv);
    if (mv) begin
      r   = exp_q[0];
      ins = r.instr;
      chk("out_pc", out_pc, r.pc);
      chk("out_opcode", out_opcode, ins[6:0]);
      chk("out_rd", out_rd, ins[11:7]);
      chk("out_func3", out_func3, ins[14:12]);
      chk("out_rs1", out_rs1, ins[19:15]);
      chk("out_rs2", out_rs2, ins[24:20]);
      chk("out_func7", out_func7, ins[31:25]);
      chk("out_imm", out_imm, r.imm);
      chk("out_rd1", out_rd1, r.rd1);
      chk("out_rd2", out_rd2, r.rd2);
      chk("out_alu_control", out_alu_control, r.ctrl);
      if (r.chk_op) chk("out_alu_op", out_alu_op, r.op);
      chk("out_illegal", out_illegal, r.ill);
      chk("e_out_illegal", e_out_illegal, r.ill_e);
    end
  endtask

  initial begin
    //          instr          we  wa  wd   imm           op  chk ctrl ill ill_e
    vecs[0]  = '{32'h01100093, 1, 1, 17, 32'd17,       2'b11, 1, 4'h0, 0, 0}; // addi x1,x0,17
    vecs[1]  = '{32'h123452B7, 1, 2, 5,  32'h12345000, 2'b00, 1, 4'hA, 0, 0}; // lui
    vecs[2]  = '{32'h002081B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h0, 0, 0}; // add
    vecs[3]  = '{32'h402081B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h1, 0, 0}; // sub
    vecs[4]  = '{32'hFE208CE3, 1, 4, 44, 32'hFFFFFFF8, 2'b01, 1, 4'h1, 0, 0}; // beq -8
    vecs[5]  = '{32'h0020A423, 0, 0, 0,  32'd8,        2'b00, 1, 4'h0, 0, 0}; // sw
    vecs[6]  = '{32'h0020C1B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h5, 0, 0}; // xor
    vecs[7]  = '{32'h4020D1B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h7, 0, 0}; // sra
    vecs[8]  = '{32'h0020E1B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h8, 0, 0}; // or
    vecs[9]  = '{32'h0020F1B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h9, 0, 0}; // and
    vecs[10] = '{32'h0020B1B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h4, 0, 0}; // sltu
    vecs[11] = '{32'h002091B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h2, 0, 0}; // sll
    vecs[12] = '{32'h4030D193, 0, 0, 0,  32'h403,      2'b11, 1, 4'h7, 0, 0}; // srai
    vecs[13] = '{32'h0030D193, 0, 0, 0,  32'd3,        2'b11, 1, 4'h6, 0, 0}; // srli
    vecs[14] = '{32'hFFF0A193, 0, 0, 0,  32'hFFFFFFFF, 2'b11, 1, 4'h3, 0, 0}; // slti -1
    vecs[15] = '{32'h004000EF, 0, 0, 0,  32'd4,        2'b00, 1, 4'h0, 0, 0}; // jal +4
    vecs[16] = '{32'hFFDFF0EF, 0, 0, 0,  32'hFFFFFFFC, 2'b00, 1, 4'h0, 0, 0}; // jal -4
    vecs[17] = '{32'h00001297, 0, 0, 0,  32'h00001000, 2'b00, 1, 4'h0, 0, 0}; // auipc
    vecs[18] = '{32'hFFC0A183, 0, 0, 0,  32'hFFFFFFFC, 2'b00, 1, 4'h0, 0, 0}; // lw -4
    vecs[19] = '{32'h00008067, 0, 0, 0,  32'd0,        2'b00, 1, 4'h0, 0, 0}; // jalr
    vecs[20] = '{32'h0000007F, 0, 0, 0,  32'd0,        2'b00, 0, 4'h0, 1, 1}; // bad opcode
    vecs[21] = '{32'h022081B3, 0, 0, 0,  32'd0,        2'b10, 0, 4'h0, 1, 1}; // func7=01
    vecs[22] = '{32'h402091B3, 0, 0, 0,  32'd0,        2'b10, 0, 4'h0, 1, 1}; // 0x20 with sll
    vecs[23] = '{32'h01F00093, 0, 0, 0,  32'd31,       2'b11, 1, 4'h0, 0, 0}; // addi x1,x0,31
    vecs[24] = '{32'h014081B3, 0, 0, 0,  32'd0,        2'b10, 1, 4'h0, 0, 1}; // add rs2=x20

    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = 32'h1000;
    we = 1'b0; wa = '0; wd = '0; flush = 1'b0; out_ready = 1'b1;
    cur = '{default: '0};

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_rd1", out_rd1, 0);
    chk("rst_out_alu_control", out_alu_control, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Table vectors, back-to-back with out_ready high
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].instr, vecs[i].imm, vecs[i].op, vecs[i].chk_op,
            vecs[i].ctrl, vecs[i].ill, vecs[i].ill_e);
      wr(vecs[i].we, vecs[i].wa, vecs[i].wd);
      step();
      in_pc += 32'd4;
    end

    // Bypass: main forwards the same-cycle write, the BYPASS=0 copy does not
    drive(32'h000302B3, 0, 2'b10, 1, 4'h0, 0, 0); // add x5,x6,x0
    wr(1, 6, 55);
    step();
    chk("bypass_on_rd1", out_rd1, 55);
    chk("bypass_off_rd1", e_out_rd1, 0);
    in_pc += 32'd4;
    wr(0, 0, 0);
    step();
    chk("bypass_off_next_rd1", e_out_rd1, 55);
    in_pc += 32'd4;

    // Out-of-range write on RV32E must not alias onto x4
    in_valid = 1'b0;
    wr(1, 20, 77);
    step();
    drive(32'h014201B3, 0, 2'b10, 1, 4'h0, 0, 1); // add x3,x4,x20
    wr(0, 0, 0);
    step();
    chk("e_x4_kept", e_out_rd1, 44);
    chk("main_x20", out_rd2, 77);
    in_pc += 32'd4;

    // Back-pressure with refresh of a stalled operand
    drive(32'h002081B3, 0, 2'b10, 1, 4'h0, 0, 0); // add x3,x1,x2
    step();
    in_pc += 32'd4;
    drive(32'h402081B3, 0, 2'b10, 1, 4'h1, 0, 0); // sub, waits
    out_ready = 1'b0;
    wr(1, 2, 99);
    step();
    chk("stall_refresh_rd2", out_rd2, 99);
    chk("e_stall_refresh_rd2", e_out_rd2, 99);
    wr(0, 0, 0);
    step();
    step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_pc += 32'd4;
    step();

    // Flush discards held and incoming; a write in the same cycle still lands
    drive(32'h002081B3, 0, 2'b10, 1, 4'h0, 0, 0);
    step();
    in_pc += 32'd4;
    drive(32'h402081B3, 0, 2'b10, 1, 4'h1, 0, 0);
    flush = 1'b1;
    wr(1, 7, 123);
    step();
    chk("flush_out_valid", out_valid, 0);
    flush = 1'b0;
    wr(0, 0, 0);
    in_pc += 32'd4;
    drive(32'h000381B3, 0, 2'b10, 1, 4'h0, 0, 0); // add x3,x7,x0
    step();
    chk("flush_write_x7", out_rd1, 123);
    in_pc += 32'd4;

    // Reset mid-stall drops the held instruction without a clock edge
    drive(32'h002081B3, 0, 2'b10, 1, 4'h0, 0, 0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_e_out_valid", e_out_valid, 0);
    chk("async_rst_out_pc", out_pc, 0);
    chk("async_rst_out_rd1", out_rd1, 0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst2_in_ready", in_ready, 1);
    in_pc += 32'd4;
    drive(32'h002081B3, 0, 2'b10, 1, 4'h0, 0, 0);
    step();
    chk("rst2_x1_zero", out_rd1, 0);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
